// File: rtl/inst_mem_loader.sv
// Byte-stream program loader: parses LEN_HI/LEN_LO/data/CSUM frames and writes 32-bit words
// into instruction memory while holding the processor.
module inst_mem_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   len_words;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       shift_q;
  logic [7:0]        csum;
  logic [15:0]       len_full;
  logic [31:0]       len_ext;
  logic              len_over;
  logic              xfer;
  logic              start_ok;
  logic              last_word;

  assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);
  assign busy       = byte_ready;
  assign xfer       = byte_valid & byte_ready;
  assign start_ok   = start && ((state == S_IDLE) || (state == S_ERR));
  assign len_full   = {len_hi_q, byte_data};
  assign len_ext    = {16'h0, len_full};
  assign len_over   = len_ext > 32'(DEPTH);
  // word_idx has one spare bit so N == DEPTH terminates without wrapping
  assign last_word  = (byte_idx == 2'd3) && (word_idx == len_words - ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
                  if (len_over)             state_nxt = S_ERR;
                  else if (len_full == '0)  state_nxt = S_CSUM;
                  else                      state_nxt = S_DATA;
                end
      S_DATA:   if (xfer && last_word) state_nxt = S_CSUM;
      S_CSUM:   if (xfer) state_nxt = (byte_data == csum) ? S_IDLE : S_ERR;
      S_ERR:    if (start) state_nxt = S_LEN_HI;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi_q   <= '0;
      len_words  <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shift_q    <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start_ok) begin
        error    <= 1'b0;
        cpu_hold <= 1'b1;
        csum     <= '0;
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (xfer && (state != S_CSUM)) csum <= csum ^ byte_data;
      if (xfer) begin
        case (state)
          S_LEN_HI: len_hi_q <= byte_data;
          S_LEN_LO: begin
            len_words <= len_full[ADDR_W:0];
            if (len_over) error <= 1'b1;
          end
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            shift_q  <= {shift_q[15:0], byte_data};
            // Word complete: strobe the write next cycle, overlapping the next word's bytes
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {shift_q, byte_data};
              imem_addr  <= BASE + 32'({word_idx, 2'b00});
              word_idx   <= word_idx + ONE;
            end
          end
          S_CSUM: begin
            if (byte_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: frame loads, checksum/length errors, empty frame,
// gapped stream with stray starts, async reset mid-frame and a full-depth load.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_cnt = 0;
  int          base;
  int          gap;

  logic [7:0] f1 [0:10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                            8'h00, 8'h00, 8'h00, 8'h08, 8'h27};

  inst_mem_loader #(.ADDR_W(8), .BASE(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1 && wr_cnt < 1024) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum_b);
    for (int i = 0; i < 10; i++) send(f1[i]);
    send(csum_b);
  endtask

  task automatic check_two_writes(input string tag, input int b0);
    check({tag, "_wrcnt"}, 32'(wr_cnt - b0), 32'd2);
    check({tag, "_addr0"}, wr_addr[b0],     32'h0000_0000);
    check({tag, "_data0"}, wr_data[b0],     32'h2008_0005);
    check({tag, "_addr1"}, wr_addr[b0 + 1], 32'h0000_0004);
    check({tag, "_data1"}, wr_data[b0 + 1], 32'h0000_0008);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #2 rst = 1'b0;
    #1;
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_addr",  imem_addr,       32'd0);
    check("rst_wdata", imem_wdata,      32'd0);
    check("rst_hold",  32'(cpu_hold),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(error),      32'd0);
    tick; tick;
    rst = 1'b1;
    tick;

    // Scenario 1: good two-word frame
    base = wr_cnt;
    pulse_start;
    check("s1_hold",  32'(cpu_hold),   32'd1);
    check("s1_busy",  32'(busy),       32'd1);
    check("s1_ready", 32'(byte_ready), 32'd1);
    send_frame(8'h27);
    check("s1_done",      32'(done),     32'd1);
    check("s1_hold_rel",  32'(cpu_hold), 32'd0);
    check("s1_err",       32'(error),    32'd0);
    tick;
    check("s1_done_pulse", 32'(done), 32'd0);
    check("s1_busy_end",   32'(busy), 32'd0);
    check_two_writes("s1", base);

    // Scenario 2: bad checksum
    base = wr_cnt;
    pulse_start;
    send_frame(8'h00);
    check("s2_done",  32'(done),       32'd0);
    check("s2_err",   32'(error),      32'd1);
    check("s2_hold",  32'(cpu_hold),   32'd1);
    check("s2_busy",  32'(busy),       32'd0);
    check("s2_ready", 32'(byte_ready), 32'd0);
    tick;
    check_two_writes("s2", base);
    pulse_start;
    check("s2_err_clr", 32'(error), 32'd0);
    check("s2_busy2",   32'(busy),  32'd1);

    // Scenario 4: empty frame (continues the frame started above)
    base = wr_cnt;
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("s4_done", 32'(done), 32'd1);
    tick;
    check("s4_done_pulse", 32'(done), 32'd0);
    check("s4_wrcnt", 32'(wr_cnt - base), 32'd0);

    // Scenario 3: length overflow (N = 257)
    base = wr_cnt;
    pulse_start;
    send(8'h01);
    send(8'h01);
    check("s3_err",   32'(error),      32'd1);
    check("s3_ready", 32'(byte_ready), 32'd0);
    check("s3_hold",  32'(cpu_hold),   32'd1);
    send(8'h55);
    send(8'h66);
    tick;
    check("s3_wrcnt", 32'(wr_cnt - base), 32'd0);
    check("s3_err_sticky", 32'(error), 32'd1);

    // Scenario 5: gapped stream with stray starts while busy (also recovers from ERR)
    base = wr_cnt;
    pulse_start;
    check("s5_err_clr", 32'(error), 32'd0);
    for (int i = 0; i < 11; i++) begin
      gap = (i == 4) ? 5 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        start = (g == 2) || (i == 7 && g == 0);
        tick;
        start = 1'b0;
      end
      send(f1[i]);
    end
    check("s5_done", 32'(done),  32'd1);
    check("s5_err",  32'(error), 32'd0);
    tick;
    check_two_writes("s5", base);

    // Scenario 6: async reset mid-frame, then a clean reload
    pulse_start;
    for (int i = 0; i < 8; i++) send(f1[i]);
    #2 rst = 1'b0;
    #1;
    check("s6_we",    32'(imem_we),    32'd0);
    check("s6_wdata", imem_wdata,      32'd0);
    check("s6_addr",  imem_addr,       32'd0);
    check("s6_hold",  32'(cpu_hold),   32'd0);
    check("s6_busy",  32'(busy),       32'd0);
    check("s6_ready", 32'(byte_ready), 32'd0);
    tick;
    rst = 1'b1;
    tick;
    base = wr_cnt;
    pulse_start;
    send_frame(8'h27);
    check("s6_done", 32'(done), 32'd1);
    tick;
    check_two_writes("s6", base);

    // Full-depth frame: N = 256 fills memory without wrapping
    base = wr_cnt;
    pulse_start;
    send(8'h01);
    send(8'h00);
    for (int k = 0; k < 256; k++) begin
      send(8'hA5);
      send(8'h00);
      send(8'h00);
      send(8'(k));
    end
    send(8'h01);
    check("full_done", 32'(done),  32'd1);
    check("full_err",  32'(error), 32'd0);
    tick;
    check("full_wrcnt",  32'(wr_cnt - base),  32'd256);
    check("full_addr0",  wr_addr[base],       32'h0000_0000);
    check("full_addr_n", wr_addr[base + 255], 32'h0000_03FC);
    check("full_data_n", wr_data[base + 255], 32'hA500_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
